// File: rtl/control_cell_pkg.sv
// Shared definitions for the multi-channel gain cell: register map, mode
// encodings, AXI response codes and the datapath precision constants.
package control_cell_pkg;

    localparam int unsigned INTERNAL_PRECISION = 64;
    localparam int unsigned DEF_NUM_DECIMAL    = 8;

    localparam int unsigned REG_CTRL      = 32'h00;
    localparam int unsigned REG_INFO      = 32'h04;
    localparam int unsigned REG_MODE      = 32'h08;
    localparam int unsigned REG_GAIN_BASE = 32'h20;
    localparam int unsigned REG_CLIP_BASE = 32'h40;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_GAIN  = 2'd1,
        MODE_MUTE  = 2'd2,
        MODE_MUTE3 = 2'd3
    } mode_e;

    function automatic int unsigned gain_addr(input int unsigned ch);
        return REG_GAIN_BASE + 4 * ch;
    endfunction

    function automatic int unsigned clip_addr(input int unsigned ch);
        return REG_CLIP_BASE + 4 * ch;
    endfunction

endpackage

// File: rtl/gain_sat_channel.sv
// One audio channel: registered signed multiply, then floor shift, saturation
// and a sticky-at-max clip counter.
module gain_sat_channel
    import control_cell_pkg::*;
#(
    parameter int unsigned VOL_MSB     = 23,
    parameter int unsigned COEF_WIDTH  = 32,
    parameter int unsigned NUM_DECIMAL = DEF_NUM_DECIMAL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [COEF_WIDTH-1:0] gain,
    input  logic [VOL_MSB:0]      in_sample,
    input  logic                  in_valid,
    input  logic                  clip_clr,
    output logic [VOL_MSB:0]      out_sample,
    output logic                  out_valid,
    output logic [31:0]           clip_cnt
);
    localparam int unsigned VW = VOL_MSB + 1;
    localparam int unsigned PW = VW + COEF_WIDTH;
    localparam int unsigned HW = PW - VOL_MSB;

    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] s1_prod;
    logic signed [PW-1:0] shifted_c;
    logic [VOL_MSB:0]     s1_sample;
    logic [1:0]           s1_mode;
    logic                 s1_valid;
    logic [HW-1:0]        hi_c;
    logic                 clip_c;
    logic [VOL_MSB:0]     result_c;

    assign prod_c = $signed({{COEF_WIDTH{in_sample[VOL_MSB]}}, in_sample})
                  * $signed({{VW{gain[COEF_WIDTH-1]}}, gain});

    // Result fits only if every bit from the output sign upward agrees.
    assign shifted_c = s1_prod >>> NUM_DECIMAL;
    assign hi_c      = shifted_c[PW-1:VOL_MSB];
    assign clip_c    = (s1_mode == MODE_GAIN) && !((&hi_c) || !(|hi_c));

    always_comb begin
        result_c = '0;
        case (s1_mode)
            MODE_PASS: result_c = s1_sample;
            MODE_GAIN: begin
                if (!clip_c)
                    result_c = shifted_c[VOL_MSB:0];
                else if (shifted_c[PW-1])
                    result_c = {1'b1, {VOL_MSB{1'b0}}};
                else
                    result_c = {1'b0, {VOL_MSB{1'b1}}};
            end
            default: result_c = '0;
        endcase
    end

    // Stage 1: capture product with the gain current in this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            s1_sample <= '0;
            s1_mode   <= 2'(MODE_PASS);
        end else begin
            s1_valid <= enable & in_valid;
            if (in_valid) begin
                s1_prod   <= prod_c;
                s1_sample <= in_sample;
                s1_mode   <= mode;
            end
        end
    end

    // Stage 2: output register and clip counter; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
            clip_cnt   <= '0;
        end else begin
            out_valid <= enable & s1_valid;
            if (s1_valid)
                out_sample <= result_c;
            if (clip_clr)
                clip_cnt <= '0;
            else if (enable && s1_valid && clip_c && (clip_cnt != 32'hFFFF_FFFF))
                clip_cnt <= clip_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/multi_channel_gain_cell.sv
// AXI4-Lite controlled multi-channel gain stage: register file here, one
// gain_sat_channel instance per channel.
module multi_channel_gain_cell
    import control_cell_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned VOL_MSB     = 23,
    parameter int unsigned COEF_WIDTH  = 32,
    parameter int unsigned NUM_DECIMAL = DEF_NUM_DECIMAL,
    parameter int unsigned ADDR_SIZE   = 8,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [ADDR_SIZE-1:0]          araddr,
    input  logic                          arvalid,
    output logic                          arready,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [1:0]                    rresp,
    output logic                          rvalid,
    input  logic                          rready,
    input  logic [ADDR_SIZE-1:0]          awaddr,
    input  logic                          awvalid,
    output logic                          awready,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH/8-1:0]       wstrb,
    input  logic                          wvalid,
    output logic                          wready,
    output logic [1:0]                    bresp,
    output logic                          bvalid,
    input  logic                          bready,
    input  logic [NUM_CH*(VOL_MSB+1)-1:0] in_data,
    input  logic [NUM_CH-1:0]             in_en,
    output logic [NUM_CH*(VOL_MSB+1)-1:0] out_data,
    output logic [NUM_CH-1:0]             out_en
);
    localparam int unsigned VW = VOL_MSB + 1;
    localparam int unsigned MW = 2 * NUM_CH;
    localparam int unsigned SW = DATA_WIDTH / 8;

    logic                  ctrl_en;
    logic                  clip_clr;
    logic [MW-1:0]         mode_reg;
    logic [COEF_WIDTH-1:0] gain [NUM_CH];
    logic [31:0]           clip_cnt [NUM_CH];
    logic [DATA_WIDTH-1:0] wmask_c;
    logic [DATA_WIDTH-1:0] rd_data_c;
    logic                  rd_err_c;
    logic                  wr_ok_c;
    logic                  wr_fire_c;

    assign wr_fire_c = awready && awvalid && wvalid;

    always_comb begin
        wmask_c = '0;
        for (int unsigned i = 0; i < SW; i++)
            wmask_c[i*8 +: 8] = {8{wstrb[i]}};
    end

    // Only CTRL, MODE and GAIN accept writes.
    always_comb begin
        wr_ok_c = (awaddr == ADDR_SIZE'(REG_CTRL)) || (awaddr == ADDR_SIZE'(REG_MODE));
        for (int unsigned ch = 0; ch < NUM_CH; ch++)
            if (awaddr == ADDR_SIZE'(gain_addr(ch)))
                wr_ok_c = 1'b1;
    end

    always_comb begin
        rd_data_c = '0;
        rd_err_c  = 1'b1;
        if (araddr == ADDR_SIZE'(REG_CTRL)) begin
            rd_data_c = DATA_WIDTH'(ctrl_en);
            rd_err_c  = 1'b0;
        end else if (araddr == ADDR_SIZE'(REG_INFO)) begin
            rd_data_c = DATA_WIDTH'({8'(NUM_DECIMAL), 8'(NUM_CH)});
            rd_err_c  = 1'b0;
        end else if (araddr == ADDR_SIZE'(REG_MODE)) begin
            rd_data_c = DATA_WIDTH'(mode_reg);
            rd_err_c  = 1'b0;
        end else begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                if (araddr == ADDR_SIZE'(gain_addr(ch))) begin
                    rd_data_c = DATA_WIDTH'(gain[ch]);
                    rd_err_c  = 1'b0;
                end
                if (araddr == ADDR_SIZE'(clip_addr(ch))) begin
                    rd_data_c = DATA_WIDTH'(clip_cnt[ch]);
                    rd_err_c  = 1'b0;
                end
            end
        end
    end

    // AXI4-Lite slave: one-cycle ready pulses, response the cycle after.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            ctrl_en  <= 1'b1;
            clip_clr <= 1'b0;
            mode_reg <= {NUM_CH{2'(MODE_GAIN)}};
            for (int unsigned ch = 0; ch < NUM_CH; ch++)
                gain[ch] <= COEF_WIDTH'(1) << NUM_DECIMAL;
        end else begin
            awready  <= 1'b0;
            wready   <= 1'b0;
            arready  <= 1'b0;
            clip_clr <= 1'b0;

            if (!awready && awvalid && wvalid && !bvalid) begin
                awready <= 1'b1;
                wready  <= 1'b1;
            end
            if (bvalid && bready)
                bvalid <= 1'b0;
            if (wr_fire_c) begin
                bvalid <= 1'b1;
                bresp  <= wr_ok_c ? RESP_OKAY : RESP_SLVERR;
                if ((awaddr == ADDR_SIZE'(REG_CTRL)) && wstrb[0]) begin
                    ctrl_en  <= wdata[0];
                    clip_clr <= wdata[1];
                end
                if (awaddr == ADDR_SIZE'(REG_MODE))
                    mode_reg <= (mode_reg & ~MW'(wmask_c)) | MW'(wdata & wmask_c);
                for (int unsigned ch = 0; ch < NUM_CH; ch++)
                    if (awaddr == ADDR_SIZE'(gain_addr(ch)))
                        gain[ch] <= (gain[ch] & ~COEF_WIDTH'(wmask_c))
                                  | COEF_WIDTH'(wdata & wmask_c);
            end

            if (!arready && arvalid && !rvalid)
                arready <= 1'b1;
            if (rvalid && rready)
                rvalid <= 1'b0;
            if (arready && arvalid) begin
                rvalid <= 1'b1;
                rdata  <= rd_data_c;
                rresp  <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        gain_sat_channel #(
            .VOL_MSB    (VOL_MSB),
            .COEF_WIDTH (COEF_WIDTH),
            .NUM_DECIMAL(NUM_DECIMAL)
        ) u_chan (
            .clk       (aclk),
            .rst_n     (aresetn),
            .enable    (ctrl_en),
            .mode      (mode_reg[2*ch +: 2]),
            .gain      (gain[ch]),
            .in_sample (in_data[ch*VW +: VW]),
            .in_valid  (in_en[ch]),
            .clip_clr  (clip_clr),
            .out_sample(out_data[ch*VW +: VW]),
            .out_valid (out_en[ch]),
            .clip_cnt  (clip_cnt[ch])
        );
    end

endmodule

// File: doc/multi_channel_gain_cell.md
MULTI_CHANNEL_GAIN_CELL -- requirements
Module: multi_channel_gain_cell

Interface
REQ-001 Parameters SHALL be: NUM_CH, default 2, channel count (1..8); VOL_MSB, default 23, sample MSB; COEF_WIDTH, default 32, signed gain width; NUM_DECIMAL, default 8, gain fractional bits; ADDR_SIZE, default 8, AXI address width; DATA_WIDTH, default 32, AXI data width.
REQ-002 Ports SHALL be: aclk in 1, the single clock; aresetn in 1, asynchronous active-low reset.
REQ-003 araddr in ADDR_SIZE, arvalid in 1, arready out 1, rdata out DATA_WIDTH, rresp out 2, rvalid out 1, rready in 1: AXI4-Lite read channels.
REQ-004 awaddr in ADDR_SIZE, awvalid in 1, awready out 1, wdata in DATA_WIDTH, wstrb in DATA_WIDTH/8, wvalid in 1, wready out 1, bresp out 2, bvalid out 1, bready in 1: AXI4-Lite write channels.
REQ-005 in_data in NUM_CH*(VOL_MSB+1) and in_en in NUM_CH SHALL carry packed signed samples, channel 0 in the LSBs.
REQ-006 out_data out NUM_CH*(VOL_MSB+1) and out_en out NUM_CH SHALL carry processed samples, packed the same way.

Function
REQ-007 Register map SHALL be: 0x00 CTRL (bit0 enable, RW; bit1 clip-clear, write-1 self-clearing, reads 0); 0x04 INFO (RO, [7:0]=NUM_CH, [15:8]=NUM_DECIMAL); 0x08 MODE (2 bits per channel, RW); 0x20+4*ch GAIN (COEF_WIDTH, RW); 0x40+4*ch CLIP (RO, 32-bit).
REQ-008 MODE encodings SHALL be: 0 pass (out=in), 1 gain, 2 mute (out=0), 3 treated as mute.
REQ-009 Write SHALL complete only when awvalid and wvalid are both high and bvalid is low; awready and wready SHALL pulse together for one cycle; bvalid SHALL rise the next cycle and hold until bready.
REQ-010 Read SHALL accept when arvalid is high and rvalid is low; arready SHALL pulse for one cycle; rvalid SHALL rise the next cycle; rdata/rresp SHALL stay stable until rready.
REQ-011 wstrb SHALL enable writes per byte; bytes with a zero strobe SHALL keep their value.
REQ-012 Unmapped or RO address: write ignored, bresp=2'b10; read rdata=0, rresp=2'b10; otherwise resp=2'b00.
REQ-013 Gain mode SHALL compute the full signed product in VOL_MSB+1+COEF_WIDTH bits, arithmetic-shift it right by NUM_DECIMAL (floor), and saturate it to [-2^VOL_MSB, 2^VOL_MSB-1].
REQ-014 out_en[ch] SHALL assert exactly 2 cycles after in_en[ch]: stage 1 registers the product using the GAIN value current in that cycle; stage 2 shifts and saturates.
REQ-015 A saturation event SHALL increment CLIP[ch] by 1 and stop at 0xFFFFFFFF; pass and mute modes SHALL never clip.
REQ-016 When clip-clear and an increment fall in the same cycle, clear SHALL win (result 0).
REQ-017 With CTRL.enable=0, incoming samples SHALL be dropped, in-flight pipeline valids SHALL be flushed, and out_en SHALL stay 0.
REQ-018 Channels SHALL be independent; simultaneous in_en on all channels SHALL be fully supported every cycle (throughput 1 sample/channel/cycle).

Reset
REQ-019 While aresetn is low, all outputs SHALL be 0: ready, valid, rdata, resp, out_data and out_en.
REQ-020 Register reset values SHALL be: CTRL=0x1; MODE=1 per channel; GAIN=1<<NUM_DECIMAL; CLIP=0.
REQ-021 Reset asserted mid-transaction or mid-stream SHALL abort the transaction and clear the pipeline; the first out_en after release SHALL come only from a post-reset in_en.

Structure
REQ-022 Package control_cell_pkg SHALL hold register offsets, MODE encodings, AXI resp codes, INTERNAL_PRECISION=64 and default NUM_DECIMAL.
REQ-023 Per-channel datapath SHALL be sub-module gain_sat_channel (2-stage multiply/shift/saturate plus clip counter), instantiated NUM_CH times by generate; the AXI register file SHALL stay in the top module.

Verification
REQ-024 Reset, then read 0x20 -> 0x00000100; read 0x08 -> 0x5; in_data ch0=0x000123 -> out ch0=0x000123 exactly 2 cycles later.
REQ-025 Write GAIN1=0x180, drive ch1=0x001000 -> 0x001800; drive ch1=0xFFFFFF with GAIN1=0x80 -> 0xFFFFFF (floor).
REQ-026 Write GAIN0=0x400, drive 0x300000 -> 0x7FFFFF and CLIP0=1; drive 0xD00000 -> 0x800000 and CLIP0=2; write CTRL=0x3 -> CLIP0=0 and CTRL reads 0x1.
REQ-027 Read 0x80 -> rresp=2'b10 and rdata=0; write 0xFFFFFFFF to GAIN0 with wstrb=4'b0001 -> reads 0x000001FF; hold rready low 5 cycles -> rvalid and rdata stable.
REQ-028 MODE=0x2 gives ch0 out=0 with out_en; CTRL=0 with in_en held high gives out_en=0; aresetn pulsed low one cycle after in_en gives no out_en.
